// File: rtl/uart_rx_framed.sv
// Framed UART receiver: start/data/optional parity/stop, LSB first, with a
// valid/ready output holding register and overrun indication.
module uart_rx_framed #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_SPEED = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_TICKS  = CLK_FREQ / UART_SPEED;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int TICK_W     = $clog2(BIT_TICKS) + 1;
    localparam int BIT_W      = 4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_TICKS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // True when the received parity bit disagrees with the configured sense.
    function automatic logic parity_error(input logic [DATA_BITS-1:0] payload,
                                          input logic                 pbit);
        logic x;
        x = (^payload) ^ pbit;
        if (PARITY == 1) return (x != 1'b1);
        if (PARITY == 2) return (x != 1'b0);
        return 1'b0;
    endfunction

    logic                 sync1_q, sync2_q;
    logic                 rxs;
    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 done;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    assign rxs = sync2_q;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == TICK_HALF) begin
                    tick_d = '0;
                    bit_d  = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == TICK_LAST) begin
                    tick_d     = '0;
                    perr_acc_d = parity_error(shift_q, rxs);
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == TICK_LAST) begin
                    tick_d     = '0;
                    ferr_acc_d = ferr_acc_q | ~rxs;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output holding register: a completion is dropped only if the previous
    // frame is still pending and not being accepted in the same cycle.
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        busy_d       = (state_d != S_IDLE);

        if (valid_q && ready) valid_d = 1'b0;

        if (done) begin
            if (!valid_q || ready) begin
                data_d       = shift_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = ferr_acc_d;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    // Shift register and per-frame accumulators are rebuilt every frame.
    always_ff @(posedge clk) begin
        shift_q    <= shift_d;
        perr_acc_q <= perr_acc_d;
        ferr_acc_q <= ferr_acc_d;
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame, legal 5..9.
REQ-002 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-003 Parameter STOP_BITS, default 1: legal 1 or 2.
REQ-004 Parameter CLK_FREQ, default 50000000: clk frequency in Hz.
REQ-005 Parameter UART_SPEED, default 115200: baud rate.
REQ-006 Derived BIT_TICKS = CLK_FREQ/UART_SPEED and HALF_TICKS = BIT_TICKS/2; BIT_TICKS shall be at least 4.
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 rst  input  1  reset; synchronous, active-high.
REQ-009 rx  input  1  asynchronous serial line, idle high.
REQ-010 data  output  DATA_BITS  last received payload.
REQ-011 valid  output  1  data and error flags hold a frame not yet accepted.
REQ-012 ready  input  1  consumer accepts the frame when valid && ready.
REQ-013 parity_err  output  1  parity mismatch for the frame in data; 0 when PARITY = 0.
REQ-014 frame_err  output  1  at least one stop bit sampled low for the frame in data.
REQ-015 overrun  output  1  one-cycle pulse when a completed frame is discarded.
REQ-016 busy  output  1  receiver is in any state other than IDLE.

Function
REQ-017 rx shall pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value rxs.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; one tick counter (width clog2(BIT_TICKS)+1) and one bit counter.
REQ-019 IDLE: on rxs == 0, clear the tick counter and go to START; the tick counter is held at 0 while in IDLE.
REQ-020 START: when tick == HALF_TICKS-1, sample rxs; if 1 (glitch), return to IDLE with no output change; if 0, clear tick and go to DATA.
REQ-021 DATA: sample rxs each time tick == BIT_TICKS-1, then clear tick; bits shift in LSB first; after DATA_BITS samples go to PARITY if PARITY != 0, else STOP.
REQ-022 PARITY: sample one bit at tick == BIT_TICKS-1; the error is set when (XOR of payload ^ parity bit) != 1 (odd) or != 0 (even).
REQ-023 STOP: sample STOP_BITS bits at BIT_TICKS-1 spacing; any low sample sets the frame error; after the last sample, complete the frame and return to IDLE immediately, without waiting for the end of the stop bit.
REQ-024 On completion, if valid == 0 or (valid && ready) in the same cycle, then on the next edge load data, parity_err and frame_err and assert valid.
REQ-025 On completion with valid == 1 && ready == 0, discard the new frame, leave data and flags unchanged, and pulse overrun high for exactly one cycle.
REQ-026 valid, data, parity_err and frame_err shall stay stable until valid && ready; on that handshake, with no new completion in the same cycle, valid clears on the next edge and data holds its value.
REQ-027 Frames with parity_err or frame_err shall still be delivered through the handshake.
REQ-028 The receiver shall never stall on ready; reception continues while valid is high.
REQ-029 Latency: valid rises 1 cycle after the clock in which the last stop bit is sampled.
REQ-030 busy is high from the cycle after IDLE exits until the cycle after the return to IDLE.

Reset
REQ-031 When rst is high: FSM goes to IDLE, counters are cleared, synchronizer flops are set to 1, data = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
REQ-032 Reset asserted mid-frame abandons the frame; after release, the receiver waits for a fresh falling edge, and a partial frame never produces valid.

Verification (BIT_TICKS = 16: CLK_FREQ = 1600000, UART_SPEED = 100000)
REQ-033 8N1, ready = 1, send 0xA5 -> valid high for exactly 1 cycle, data = 0xA5, parity_err = 0, frame_err = 0, overrun never pulses.
REQ-034 PARITY = 2, send 0x03 with parity bit 1 -> data = 0x03, parity_err = 1; resend with parity bit 0 -> parity_err = 0.
REQ-035 8N1, send 0x5A with the stop bit driven low -> data = 0x5A, frame_err = 1; the next clean 0x11 frame gives frame_err = 0.
REQ-036 Drive rx low for 4 cycles then high -> busy pulses, FSM returns to IDLE, valid stays 0.
REQ-037 ready = 0, send 0x12 then 0x34 -> data = 0x12 held with valid = 1, one overrun pulse on 0x34 completion; raising ready clears valid and data stays 0x12.
REQ-038 Assert rst during data bit 3 of 0xFF, release, send 0x3C -> a single valid with data = 0x3C.
